routercc: RTL and testbench

ROUTERCC -- requirements
Module: routercc

---
 rtl/routercc_pkg.sv | 43 ++++
 rtl/router_fifo.sv | 64 ++++++
 rtl/routercc.sv | 159 +++++++++++++++
 tb/tb_routercc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/routercc_pkg.sv
// rtl/routercc_pkg.sv - shared constants, port indices, FSM state type and XY route helper
// Purpose : common definitions for the routercc router and its input buffers.
// Contents: flit/buffer sizes, port index constants, switch FSM state type,
//           xy_route() which maps a target {X, Y} to an output port index.
package routercc_pkg;

  localparam int TAM_FLIT   = 16;
  localparam int METADEFLIT = TAM_FLIT / 2;
  localparam int NPORT      = 5;
  localparam int TAM_BUFFER = 16;
  localparam int PTR_W      = $clog2(TAM_BUFFER);

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ROUTE = 2'd2,
    S_GRANT = 2'd3
  } sw_state_t;

  // X is resolved first, then Y; equal coordinates deliver locally.
  function automatic logic [2:0] xy_route(input logic [TAM_FLIT-1:0] target,
                                          input logic [TAM_FLIT-1:0] own);
    logic [METADEFLIT-1:0] tgt_x, tgt_y, own_x, own_y;
    logic [2:0]            port;
    tgt_x = target[TAM_FLIT-1:METADEFLIT];
    tgt_y = target[METADEFLIT-1:0];
    own_x = own[TAM_FLIT-1:METADEFLIT];
    own_y = own[METADEFLIT-1:0];
    if (tgt_x > own_x)      port = EAST;
    else if (tgt_x < own_x) port = WEST;
    else if (tgt_y > own_y) port = NORTH;
    else if (tgt_y < own_y) port = SOUTH;
    else                    port = LOCAL;
    return port;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - TAM_BUFFER-deep input flit buffer with registered not-full flag
// Purpose : per-port input buffer of the router.
// Ports   : clock, reset (async, active-low)
//           wr_en_i/wr_data_i  - write request and flit (ignored while full)
//           rd_en_i            - pop head (ignored while empty)
//           rd_data_o          - current head flit
//           empty_o            - buffer holds no flit
//           not_full_o         - registered not-full flag, drives credit_o
module router_fifo
  import routercc_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [TAM_FLIT-1:0] wr_data_i,
  input  logic                rd_en_i,
  output logic [TAM_FLIT-1:0] rd_data_o,
  output logic                empty_o,
  output logic                not_full_o
);

  logic [TAM_FLIT-1:0] mem_q [TAM_BUFFER];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q, count_d;
  logic                not_full_q;
  logic                push, pop;

  assign push = wr_en_i && not_full_q;
  assign pop  = rd_en_i && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The flag is computed from the next count so it drops on the very edge
  // that stores the last free slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      not_full_q <= (count_d != (PTR_W+1)'(TAM_BUFFER));
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign empty_o    = (count_q == '0);
  assign not_full_o = not_full_q;

endmodule

// File: rtl/routercc.sv
// rtl/routercc.sv - 5-port XY-routed wormhole router with round-robin switch control
// Purpose : buffers flits per input, arbitrates headers round-robin, routes XY and
//           streams each packet (header, size N, N payload) through a held connection.
// Ports   : clock, reset (async, active-low), rx/data_in/credit_o (input side),
//           tx/data_out/credit_i (output side), clock_rx (unused), clock_tx (= clock).
// Macro   : ROUTERCC_ASSERT_EN enables simulation-only protocol checks.
module routercc
  import routercc_pkg::*;
#(
  parameter logic [TAM_FLIT-1:0] address = 16'h0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NPORT-1:0]          rx,
  input  logic [NPORT-1:0]          clock_rx,
  input  logic [NPORT*TAM_FLIT-1:0] data_in,
  input  logic [NPORT-1:0]          credit_i,
  output logic [NPORT-1:0]          credit_o,
  output logic [NPORT-1:0]          tx,
  output logic [NPORT-1:0]          clock_tx,
  output logic [NPORT*TAM_FLIT-1:0] data_out
);

  logic [NPORT-1:0][TAM_FLIT-1:0] head;
  logic [NPORT-1:0]               empty, pop, req;
  logic [NPORT-1:0]               in_busy_q, out_busy_q;
  logic [NPORT-1:0][2:0]          in_dst_q, out_src_q;
  logic [NPORT-1:0][1:0]          stage_q;
  logic [NPORT-1:0][TAM_FLIT-1:0] rem_q;
  sw_state_t                      state_q;
  logic [2:0]                     rr_ptr_q, sel_q, route_d, arb_pick;
  logic                           arb_hit;
  int                             cand;
  logic                           unused_clock_rx;

  assign unused_clock_rx = ^clock_rx;
  assign clock_tx        = {NPORT{clock}};

  for (genvar p = 0; p < NPORT; p++) begin : g_in
    router_fifo u_fifo (
      .clock      (clock),
      .reset      (reset),
      .wr_en_i    (rx[p]),
      .wr_data_i  (data_in[p*TAM_FLIT +: TAM_FLIT]),
      .rd_en_i    (pop[p]),
      .rd_data_o  (head[p]),
      .empty_o    (empty[p]),
      .not_full_o (credit_o[p])
    );
    assign pop[p] = in_busy_q[p] && !empty[p] && credit_i[in_dst_q[p]];
    // Only an unconnected input with a flit at its head can be holding a header.
    assign req[p] = !empty[p] && !in_busy_q[p];
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    assign tx[o] = out_busy_q[o] && !empty[out_src_q[o]];
    assign data_out[o*TAM_FLIT +: TAM_FLIT] = tx[o] ? head[out_src_q[o]] : '0;
  end

  // Round-robin: search starts one past the last granted input.
  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = rr_ptr_q;
    cand     = 0;
    for (int k = 1; k <= NPORT; k++) begin
      cand = (int'(rr_ptr_q) + k) % NPORT;
      if (!arb_hit && req[cand]) begin
        arb_hit  = 1'b1;
        arb_pick = 3'(cand);
      end
    end
  end

  assign route_d = xy_route(head[sel_q], address);

  // Connection and FSM state share one block. The route decided in ROUTE is
  // committed on the edge into GRANT, so the path is live while GRANT is held
  // and the header leaves three edges after it was written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= LOCAL;
      sel_q      <= LOCAL;
      in_busy_q  <= '0;
      out_busy_q <= '0;
      in_dst_q   <= '0;
      out_src_q  <= '0;
      stage_q    <= '0;
      rem_q      <= '0;
    end else begin
      // Track packet position per connected input; stage 0 header, 1 size, 2 payload.
      for (int p = 0; p < NPORT; p++) begin
        if (pop[p]) begin
          case (stage_q[p])
            2'd0: stage_q[p] <= 2'd1;
            2'd1: begin
              rem_q[p] <= head[p];
              if (head[p] == '0) begin
                in_busy_q[p]             <= 1'b0;
                out_busy_q[in_dst_q[p]]  <= 1'b0;
                stage_q[p]               <= 2'd0;
              end else begin
                stage_q[p] <= 2'd2;
              end
            end
            default: begin
              rem_q[p] <= rem_q[p] - 1'b1;
              if (rem_q[p] == TAM_FLIT'(1)) begin
                in_busy_q[p]             <= 1'b0;
                out_busy_q[in_dst_q[p]]  <= 1'b0;
                stage_q[p]               <= 2'd0;
              end
            end
          endcase
        end
      end

      case (state_q)
        S_IDLE: if (|req) state_q <= S_ARB;
        S_ARB: begin
          if (arb_hit) begin
            sel_q   <= arb_pick;
            state_q <= S_ROUTE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ROUTE: begin
          // A busy output leaves the header waiting for a later pass.
          if (!out_busy_q[route_d]) begin
            in_busy_q[sel_q]     <= 1'b1;
            in_dst_q[sel_q]      <= route_d;
            out_busy_q[route_d]  <= 1'b1;
            out_src_q[route_d]   <= sel_q;
            rr_ptr_q             <= sel_q;
          end
          state_q <= S_GRANT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ROUTERCC_ASSERT_EN
  always @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NPORT; p++) begin
        if (rx[p] && !credit_o[p])
          $error("routercc: rx[%0d] asserted while credit_o[%0d] is low", p, p);
      end
      if (state_q == S_ROUTE && route_d == sel_q && sel_q != LOCAL)
        $error("routercc: header on input %0d routes back to its own port", sel_q);
    end
  end
`else
  // Checks are compiled out in this build.
`endif

endmodule

// File: tb/tb_routercc.sv
// tb/tb_routercc.sv - randomized self-checking bench for routercc against a packet-level model
module tb_routercc;
  import routercc_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NPORT-1:0]          rx, clock_rx, credit_i, credit_o, tx, clock_tx;
  logic [NPORT*TAM_FLIT-1:0] data_in, data_out;

  routercc #(.address(16'h0101)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .clock_rx (clock_rx),
    .data_in  (data_in),
    .credit_i (credit_i),
    .credit_o (credit_o),
    .tx       (tx),
    .clock_tx (clock_tx),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [15:0] src_q [5][$];
  logic [15:0] exp_q [5][$];
  logic [15:0] got_q [5][$];

  int         checks = 0;
  int         errors = 0;
  bit         stall_en = 0;
  logic [4:0] credit_mask = 5'h1f;
  int         hdr_cyc = -1;
  int         first_tx = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Router sits at X=1, Y=1.
  function automatic int model_port(input logic [15:0] tgt);
    int x, y;
    x = int'(tgt[15:8]);
    y = int'(tgt[7:0]);
    if (x > 1) return 0;
    if (x < 1) return 1;
    if (y > 1) return 2;
    if (y < 1) return 3;
    return 4;
  endfunction

  task automatic add_packet(input int src, input logic [15:0] tgt, input int n);
    int          d;
    logic [15:0] f;
    d = model_port(tgt);
    src_q[src].push_back(tgt);
    exp_q[d].push_back(tgt);
    src_q[src].push_back(16'(n));
    exp_q[d].push_back(16'(n));
    for (int i = 0; i < n; i++) begin
      f = 16'($urandom);
      src_q[src].push_back(f);
      exp_q[d].push_back(f);
    end
  endtask

  // One cycle: account for flits written on the last edge, then drive the
  // next cycle's credits/flits and record transfers that the next edge makes.
  task automatic step();
    @(negedge clock);
    for (int p = 0; p < NPORT; p++)
      if (rx[p]) void'(src_q[p].pop_front());
    credit_i = credit_mask & (stall_en ? 5'($urandom) : 5'h1f);
    for (int o = 0; o < NPORT; o++)
      if (tx[o] && credit_i[o]) got_q[o].push_back(data_out[o*16 +: 16]);
    if (tx[4] && first_tx < 0) first_tx = cyc;
    for (int p = 0; p < NPORT; p++) begin
      if (src_q[p].size() > 0 && credit_o[p]) begin
        rx[p] = 1'b1;
        data_in[p*16 +: 16] = src_q[p][0];
        if (p == 4 && hdr_cyc < 0) hdr_cyc = cyc + 1;
      end else begin
        rx[p] = 1'b0;
        data_in[p*16 +: 16] = 16'h0;
      end
    end
  endtask

  function automatic bit all_done();
    for (int p = 0; p < NPORT; p++) begin
      if (src_q[p].size() != 0) return 1'b0;
      if (got_q[p].size() < exp_q[p].size()) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = all_done();
    end
    check({tag, "_drained"}, 32'(done), 32'd1);
    repeat (5) step();
  endtask

  task automatic compare_outputs(input string tag);
    int n;
    for (int o = 0; o < NPORT; o++) begin
      check($sformatf("%s_len_o%0d", tag, o), got_q[o].size(), exp_q[o].size());
      n = (got_q[o].size() < exp_q[o].size()) ? got_q[o].size() : exp_q[o].size();
      for (int i = 0; i < n; i++)
        check($sformatf("%s_o%0d_f%0d", tag, o, i), 32'(got_q[o][i]), 32'(exp_q[o][i]));
      got_q[o].delete();
      exp_q[o].delete();
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < NPORT; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      got_q[p].delete();
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    rx = '0;
    data_in = '0;
    clear_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bit         used [5];
    logic [15:0] tgt;
    int          d;
    reset    = 1'b0;
    rx       = '0;
    data_in  = '0;
    credit_i = 5'h1f;
    clock_rx = 5'b10101;

    #12;
    check("rst_credit_o", 32'(credit_o), 32'h1f);
    check("rst_tx", 32'(tx), 32'h0);
    check("rst_data_out_zero", 32'(data_out != '0), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Local to local with header latency.
    hdr_cyc  = -1;
    first_tx = -1;
    src_q[4] = '{16'h0101, 16'h0002, 16'haaaa, 16'hbbbb};
    exp_q[4] = '{16'h0101, 16'h0002, 16'haaaa, 16'hbbbb};
    drain("local", 200);
    check("local_hdr_latency", 32'(first_tx - hdr_cyc), 32'd3);
    compare_outputs("local");

    // XY routing to each neighbour from the LOCAL input.
    add_packet(4, 16'h0201, 1);
    add_packet(4, 16'h0001, 2);
    add_packet(4, 16'h0102, 0);
    add_packet(4, 16'h0100, 3);
    drain("xy", 300);
    compare_outputs("xy");

    // Backpressure: 20-flit packet to EAST with EAST credit withheld.
    add_packet(4, 16'h0201, 18);
    credit_mask = 5'b11110;
    repeat (40) step();
    check("bp_credit_low", 32'(credit_o[4]), 32'd0);
    check("bp_accepted", 32'(20 - src_q[4].size()), 32'd16);
    check("bp_held", got_q[0].size(), 32'd0);
    credit_mask = 5'h1f;
    drain("bp", 300);
    compare_outputs("bp");

    // Contention: WEST and NORTH both to EAST; after reset WEST wins first.
    pulse_reset();
    add_packet(1, 16'h0201, 2);
    add_packet(2, 16'h0201, 3);
    drain("cont", 300);
    compare_outputs("cont");

    // Randomized disjoint traffic with random downstream stalls.
    stall_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int o = 0; o < NPORT; o++) used[o] = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
        for (int t = 0; t < 20; t++) begin
          tgt = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
          d = model_port(tgt);
          if (!used[d] && (d != p || p == 4)) begin
            add_packet(p, tgt, $urandom_range(0, 6));
            used[d] = 1'b1;
            break;
          end
        end
      end
      drain("rand", 600);
      compare_outputs("rand");
    end
    stall_en = 1'b0;

    // Mid-packet reset, then a fresh packet.
    add_packet(4, 16'h0201, 10);
    for (int i = 0; i < 50 && !tx[0]; i++) step();
    check("mr_started", 32'(tx[0]), 32'd1);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("mr_tx", 32'(tx), 32'h0);
    check("mr_credit_o", 32'(credit_o), 32'h1f);
    check("mr_data_out_zero", 32'(data_out != '0), 32'h0);
    rx = '0;
    data_in = '0;
    clear_all();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    add_packet(4, 16'h0100, 2);
    drain("mr_fresh", 200);
    compare_outputs("mr_fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
